// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment bus: debounces each
// digit dwell, decodes the glyph to a 5-bit code and publishes complete 4-digit frames.
module seg_scan_decoder #(
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic        dp,
   input  logic [3:0]  an,
   output logic [19:0] chars,
   output logic [3:0]  dps,
   output logic        frame_valid,
   output logic [15:0] frame_count,
   output logic        err_multi
);

   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      case (s)
         7'h40:   return 5'd0;
         7'h79:   return 5'd1;
         7'h24:   return 5'd2;
         7'h30:   return 5'd3;
         7'h19:   return 5'd4;
         7'h12:   return 5'd5;
         7'h02:   return 5'd6;
         7'h78:   return 5'd7;
         7'h00:   return 5'd8;
         7'h10:   return 5'd9;
         7'h08:   return 5'd10;
         7'h03:   return 5'd11;
         7'h46:   return 5'd12;
         7'h21:   return 5'd13;
         7'h06:   return 5'd14;
         7'h0E:   return 5'd15;
         7'h09:   return 5'd16;
         7'h47:   return 5'd17;
         7'h2F:   return 5'd18;
         7'h7F:   return 5'd19;
         7'h3F:   return 5'd20;
         default: return 5'd31;
      endcase
   endfunction

   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;
   logic [11:0]      prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       seen_q, seen_d;
   logic [3:0][4:0]  slot_q, slot_d;
   logic [3:0]       dpslot_q, dpslot_d;
   logic [19:0]      chars_q, chars_d;
   logic [3:0]       dps_q, dps_d;
   logic             frame_valid_q, frame_valid_d;
   logic [15:0]      frame_count_q, frame_count_d;
   logic             err_multi_q, err_multi_d;

   logic [11:0] cur;
   logic [1:0]  idx;
   logic [3:0]  seen_cap;
   logic        valid, multi, same, capture, publish;
   int          zeros;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      seg_d  = seg;
      dp_d   = dp;
      an_d   = an;
      cur    = {an_q, seg_q, dp_q};
      prev_d = cur;
      zeros  = $countones(~an_q);
      valid  = (zeros == 1);
      multi  = (zeros >= 2);
      same   = (cur == prev_q);

      case (an_q)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase

      if (valid && same)
         cnt_d = (cnt_q == CNT_W'(SETTLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
      else
         cnt_d = valid ? CNT_W'(1) : CNT_W'(0);

      // The SETTLE-1 -> SETTLE transition fires once per dwell; saturation blocks repeats.
      capture  = valid && same && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
      seen_cap = seen_q | (capture ? (4'(1) << idx) : 4'b0000);
      publish  = capture && (seen_cap == 4'hF);

      slot_d   = slot_q;
      dpslot_d = dpslot_q;
      if (capture) begin
         slot_d[idx]   = decode_seg(seg_q);
         dpslot_d[idx] = ~dp_q;
      end

      seen_d        = publish ? 4'b0000 : seen_cap;
      chars_d       = publish ? slot_d : chars_q;
      dps_d         = publish ? dpslot_d : dps_q;
      frame_valid_d = publish;
      frame_count_d = frame_count_q + {15'd0, publish};
      err_multi_d   = err_multi_q | multi;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q         <= 7'h7F;
         dp_q          <= 1'b1;
         an_q          <= 4'hF;
         prev_q        <= 12'hFFF;
         cnt_q         <= '0;
         seen_q        <= 4'b0000;
         // NOTE: slot storage is reset too, so a reset mid-frame leaves no stale digits behind.
         slot_q        <= '0;
         dpslot_q      <= 4'b0000;
         chars_q       <= '0;
         dps_q         <= 4'b0000;
         frame_valid_q <= 1'b0;
         frame_count_q <= '0;
         err_multi_q   <= 1'b0;
      end else begin
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         seen_q        <= seen_d;
         slot_q        <= slot_d;
         dpslot_q      <= dpslot_d;
         chars_q       <= chars_d;
         dps_q         <= dps_d;
         frame_valid_q <= frame_valid_d;
         frame_count_q <= frame_count_d;
         err_multi_q   <= err_multi_d;
      end
   end

   assign chars       = chars_q;
   assign dps         = dps_q;
   assign frame_valid = frame_valid_q;
   assign frame_count = frame_count_q;
   assign err_multi   = err_multi_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a dwell-level model predicts each frame,
// and every frame_valid pulse is popped and compared against the prediction.
module tb_seg_scan_decoder;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [19:0] chars;
   logic [3:0]  dps;
   logic        frame_valid;
   logic [15:0] frame_count;
   logic        err_multi;

   seg_scan_decoder #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .seg(seg), .dp(dp), .an(an),
      .chars(chars), .dps(dps), .frame_valid(frame_valid),
      .frame_count(frame_count), .err_multi(err_multi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] chars;
      logic [3:0]  dps;
      logic [15:0] count;
   } frame_t;

   frame_t     exp_q[$];
   int         passed = 0;
   int         total  = 0;
   int         pulses = 0;
   bit         prev_fv = 1'b0;
   logic [4:0] m_slot[4];
   logic       m_dp[4];
   logic [3:0] m_seen;
   logic [15:0] m_count;

   logic [6:0] pats[21] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                            7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                            7'h06, 7'h0E, 7'h09, 7'h47, 7'h2F, 7'h7F, 7'h3F};

   function automatic logic [4:0] ref_code(input logic [6:0] s);
      for (int k = 0; k < 16; k++)
         if (pats[k] == s) return 5'(k);
      case (s)
         7'h09:   return 5'd16;
         7'h47:   return 5'd17;
         7'h2F:   return 5'd18;
         7'h7F:   return 5'd19;
         7'h3F:   return 5'd20;
         default: return 5'd31;
      endcase
   endfunction

   // One clock; the scoreboard is serviced whenever the DUT publishes a frame.
   task automatic tick();
      frame_t e;
      @(posedge clk);
      #1;
      if (frame_valid === 1'b1) begin
         pulses++;
         total++;
         if (prev_fv) $display("FAIL adjacent_pulse: frame_valid high on two consecutive cycles");
         else passed++;
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_frame: got chars=%h dps=%b count=%0d, no frame expected",
                     chars, dps, frame_count);
         end else begin
            e = exp_q.pop_front();
            if ({chars, dps, frame_count} !== {e.chars, e.dps, e.count})
               $display("FAIL frame: got chars=%h dps=%b count=%0d, want chars=%h dps=%b count=%0d",
                        chars, dps, frame_count, e.chars, e.dps, e.count);
            else passed++;
         end
      end
      prev_fv = (frame_valid === 1'b1);
   endtask

   task automatic dwell(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
      int i;
      frame_t e;
      an  = a;
      seg = s;
      dp  = d;
      if ($countones(~a) == 1 && len >= S) begin
         i = 0;
         for (int k = 0; k < 4; k++) if (!a[k]) i = k;
         m_slot[i] = ref_code(s);
         m_dp[i]   = ~d;
         m_seen[i] = 1'b1;
         if (m_seen == 4'hF) begin
            m_count++;
            e.chars = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            e.dps   = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
            e.count = m_count;
            exp_q.push_back(e);
            m_seen = 4'b0000;
         end
      end
      repeat (len) tick();
   endtask

   task automatic idle(input int len);
      dwell(4'hF, 7'h7F, 1'b1, len);
   endtask

   task automatic do_reset();
      an  = 4'hF;
      seg = 7'h7F;
      dp  = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_slot[k] = 5'd0;
         m_dp[k]   = 1'b0;
      end
      m_seen  = 4'b0000;
      m_count = 16'd0;
      exp_q.delete();
      prev_fv = 1'b0;
      pulses  = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (chars !== 20'd0) $display("FAIL reset_chars: got %h want 0", chars); else passed++;
      total++; if (dps !== 4'd0) $display("FAIL reset_dps: got %b want 0000", dps); else passed++;
      total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid); else passed++;
      total++; if (frame_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", frame_count); else passed++;
      total++; if (err_multi !== 1'b0) $display("FAIL reset_err: got %b want 0", err_multi); else passed++;
   endtask

   task automatic test_hello();
      do_reset();
      dwell(4'b1110, 7'h09, 1'b1, 8);
      dwell(4'b1101, 7'h06, 1'b1, 8);
      dwell(4'b1011, 7'h47, 1'b1, 8);
      dwell(4'b0111, 7'h47, 1'b1, 8);
      idle(6);
      total++; if (pulses != 1) $display("FAIL hello_pulses: got %0d want 1", pulses); else passed++;
      total++;
      if (chars !== {5'd17, 5'd17, 5'd14, 5'd16}) $display("FAIL hello_chars: got %h want %h", chars, {5'd17, 5'd17, 5'd14, 5'd16});
      else passed++;
      total++; if (dps !== 4'b0000) $display("FAIL hello_dps: got %b want 0000", dps); else passed++;
      total++; if (frame_count !== 16'd1) $display("FAIL hello_count: got %0d want 1", frame_count); else passed++;
   endtask

   task automatic test_glitch();
      do_reset();
      dwell(4'b1110, 7'h00, 1'b1, 2);
      for (int i = 0; i < 4; i++) dwell(~(4'(1) << i), 7'h40, 1'b1, 8);
      idle(6);
      total++; if (chars !== 20'd0) $display("FAIL glitch_chars: got %h want 0", chars); else passed++;
      total++; if (pulses != 1) $display("FAIL glitch_pulses: got %0d want 1", pulses); else passed++;
   endtask

   task automatic test_overwrite();
      do_reset();
      dwell(4'b1110, 7'h79, 1'b1, 8);
      dwell(4'b1110, 7'h24, 1'b1, 8);
      dwell(4'b1101, 7'h40, 1'b1, 8);
      dwell(4'b1011, 7'h40, 1'b1, 8);
      total++; if (pulses != 0) $display("FAIL overwrite_early: got %0d pulses want 0", pulses); else passed++;
      dwell(4'b0111, 7'h40, 1'b1, 8);
      idle(6);
      total++; if (pulses != 1) $display("FAIL overwrite_pulses: got %0d want 1", pulses); else passed++;
      total++; if (chars[4:0] !== 5'd2) $display("FAIL overwrite_digit0: got %0d want 2", chars[4:0]); else passed++;
   endtask

   task automatic test_errors();
      do_reset();
      dwell(4'b1100, 7'h40, 1'b1, 1);
      idle(3);
      total++; if (err_multi !== 1'b1) $display("FAIL err_set: got %b want 1", err_multi); else passed++;
      dwell(4'b1110, 7'h40, 1'b1, 8);
      dwell(4'b1101, 7'h79, 1'b0, 8);
      dwell(4'b1011, 7'h55, 1'b1, 8);
      dwell(4'b0111, 7'h24, 1'b1, 8);
      idle(6);
      total++; if (pulses != 1) $display("FAIL err_pulses: got %0d want 1", pulses); else passed++;
      total++; if (chars[14:10] !== 5'd31) $display("FAIL err_unknown: got %0d want 31", chars[14:10]); else passed++;
      total++; if (dps !== 4'b0010) $display("FAIL err_dps: got %b want 0010", dps); else passed++;
      total++; if (err_multi !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_multi); else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) dwell(~(4'(1) << i), 7'h30, 1'b0, 8);
      do_reset();
      total++;
      if ({chars, dps, frame_valid, frame_count, err_multi} !== 42'd0)
         $display("FAIL midreset_outputs: got chars=%h dps=%b fv=%b count=%0d err=%b want all 0",
                  chars, dps, frame_valid, frame_count, err_multi);
      else passed++;
      dwell(4'b0111, 7'h30, 1'b1, 8);
      idle(6);
      total++; if (pulses != 0) $display("FAIL midreset_partial: got %0d pulses want 0", pulses); else passed++;
      for (int i = 0; i < 4; i++) dwell(~(4'(1) << i), pats[i + 5], 1'b1, 8);
      idle(6);
      total++; if (frame_count !== 16'd1) $display("FAIL midreset_count: got %0d want 1", frame_count); else passed++;
   endtask

   task automatic test_continuous();
      do_reset();
      for (int f = 0; f < 100; f++)
         for (int i = 0; i < 4; i++)
            dwell(~(4'(1) << i), pats[(f * 4 + i) % 21], ((f + i) % 3) != 0, 10);
      idle(6);
      total++; if (frame_count !== 16'd100) $display("FAIL cont_count: got %0d want 100", frame_count); else passed++;
      total++; if (pulses != 100) $display("FAIL cont_pulses: got %0d want 100", pulses); else passed++;
      total++; if (exp_q.size() != 0) $display("FAIL cont_missing: got %0d frames unseen want 0", exp_q.size()); else passed++;
   endtask

   initial begin
      test_reset();
      test_hello();
      test_glitch();
      test_overwrite();
      test_errors();
      test_reset_mid();
      test_continuous();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the HelloWorld 4-digit multiplexed 7-segment driver.
- Samples the multiplexed seg/dp/an bus and rejects scan transitions and ghosting.
- Captures each digit's segment pattern and decodes it to a 5-bit character code.
- Publishes a complete 4-character frame with a one-cycle strobe. Used as a bench monitor and as an on-chip display loopback checker.

Parameters:
- SETTLE_CYCLES, 16, consecutive identical valid samples required before a digit is captured; legal range 2..255.
- CNT_W, 8, width of the stable-run counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- seg  input  7  segment lines, active-low; seg[0]=a … seg[6]=g.
- dp  input  1  decimal point, active-low.
- an  input  4  anode selects, active-low; an[i]=0 selects digit i.
- chars  output  20  decoded frame; digit i code at chars[5i+4:5i].
- dps  output  4  decimal point per digit; 1 = lit.
- frame_valid  output  1  one-cycle pulse when chars/dps update.
- frame_count  output  16  number of frames published; wraps 0xFFFF→0.
- err_multi  output  1  sticky; set when more than one an bit is 0 at the same time.

Behaviour:
- Reset (rst=1 at an edge):
  - chars=0, dps=0, frame_valid=0, frame_count=0, err_multi=0.
  - Internal input registers = idle (an=4'hF, seg=7'h7F, dp=1).
  - Run counter=0, seen=4'b0000, all slot registers cleared.
  - Reset mid-frame discards partially captured digits.
- Input stage: seg, dp and an are registered once (seg_q, dp_q, an_q). All decisions use the registered values.
- Validity: an_q is valid only if exactly one bit is 0.
  - an_q=4'hF is idle: no error, run counter=0.
  - Two or more zero bits: err_multi←1 and run counter=0.
- Run counter:
  - Increments when the current {an_q, seg_q, dp_q} is valid and equal to the previous cycle's value; saturates at SETTLE_CYCLES.
  - Otherwise it loads 1 if the current value is valid, or 0 if it is not.
- Capture:
  - Happens on the edge where the counter goes from SETTLE_CYCLES-1 to SETTLE_CYCLES. This is exactly once per dwell.
  - Slot[i] ← decode(seg_q), dpslot[i] ← ~dp_q, seen[i] ← 1, where i is the index of the zero bit in an_q.
  - A later dwell on the same digit overwrites its slot with the newest value.
  - A dwell shorter than SETTLE_CYCLES samples captures nothing.
- Frame publish:
  - Triggered on the edge where a capture makes seen equal 4'b1111, with the new capture included.
  - chars ← all slots, dps ← dpslots, frame_valid=1 for that single cycle, frame_count+1, seen ← 4'b0000.
  - frame_valid is 0 in every other cycle.
- Decode (seg as an active-low hex value → code):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E map to codes 0–15.
  - H:09→16, L:47→17, r:2F→18, blank:7F→19, dash:3F→20.
  - Any other pattern → 31.
  - 'O' shares 7'h40 with '0' and decodes to 0.
- Latency: with an input held stable from edge T, capture occurs at edge T+SETTLE_CYCLES, and frame_valid rises on that same edge when it completes the set.
- err_multi stays set until rst. It does not block captures once an becomes valid again.

Test Plan:
- SETTLE_CYCLES=4; dwell 8 cycles each on an=1110/1101/1011/0111 with seg=09/06/47/47, dp=1 → exactly one frame_valid pulse; chars digit0..3 = 16,14,17,17; dps=0; frame_count=1.
- Glitch rejection: 2-cycle dwell on an=1110 with seg=7'h00, then full dwells on all four digits with seg=7'h40 → chars all 0, not 8; exactly one frame.
- Overwrite: two full dwells on digit 0 (seg 79, then 24) before digits 1–3 → digit0 code = 2; frame_valid only after digit 3 captures.
- Errors and unknowns: an=1100 for one cycle → err_multi=1 and stays 1. seg=7'h55 on digit 2 → code 31. dp=0 on digit 1 → dps=4'b0010.
- Reset mid-frame: capture digits 0–2, assert rst for 1 cycle, then capture digit 3 only → no frame_valid. All outputs are 0 after reset. A full 4-digit scan afterwards yields frame_count=1.
- Continuous scan: HelloWorld-style rotation at 10 cycles/digit for 100 frames → frame_count=100, 100 single-cycle pulses, no pulse adjacent to another.
